// File: rtl/delay_line_prog_if.sv
// Data, configuration and status signals of the programmable delay line.
interface delay_line_prog_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DLY_W = 4
);
  logic [WIDTH-1:0] i_d;
  logic             i_vld;
  logic             i_cfg_vld;
  logic [DLY_W-1:0] i_cfg_dly;
  logic             i_cfg_inv;
  logic             o_cfg_rdy;
  logic [WIDTH-1:0] o_z;
  logic             o_vld;
  logic [DLY_W-1:0] o_dly;
  logic             o_busy;

  modport master (
    output i_d, i_vld, i_cfg_vld, i_cfg_dly, i_cfg_inv,
    input  o_cfg_rdy, o_z, o_vld, o_dly, o_busy
  );

  modport slave (
    input  i_d, i_vld, i_cfg_vld, i_cfg_dly, i_cfg_inv,
    output o_cfg_rdy, o_z, o_vld, o_dly, o_busy
  );
endinterface

// File: rtl/delay_line_prog.sv
// Programmable delay line: DMAX-stage shift register with a selectable tap,
// optional output inversion and a flush phase after every reconfiguration.
module delay_line_prog #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned DLY_W   = 4,
  parameter int unsigned RST_DLY = 10
) (
  input logic               i_clk,
  input logic               i_rst,
  delay_line_prog_if.slave  bus
);

  localparam int unsigned DMAX = (1 << DLY_W) - 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             inv_q, inv_d;
  logic             cfg_acc_c;
  logic             cfg_rdy_c;
  logic             busy_c;

  // Stage k+1 of the line lives at index k.
  logic [WIDTH-1:0] dat_q [DMAX];
  logic [DMAX-1:0]  vld_q;

  logic [DLY_W-1:0] sel_c;
  logic [WIDTH-1:0] inv_mask_c;
  logic [WIDTH-1:0] z_c;
  logic             vld_c;

  // Control registers: state, active delay, inversion and flush counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      dly_q   <= DLY_W'(RST_DLY);
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; flush ends on the edge where the decremented count hits zero.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    cfg_acc_c = 1'b0;
    cfg_rdy_c = 1'b0;
    busy_c    = 1'b0;
    case (state_q)
      ST_RUN: begin
        cfg_rdy_c = 1'b1;
        if (bus.i_cfg_vld) begin
          cfg_acc_c = 1'b1;
          dly_d     = bus.i_cfg_dly;
          inv_d     = bus.i_cfg_inv;
          cnt_d     = bus.i_cfg_dly;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        busy_c = 1'b1;
        if (cnt_q <= DLY_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // First stage captures the input; its valid is dropped on a config edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dat_q[0] <= '0;
      vld_q[0] <= 1'b0;
    end else begin
      dat_q[0] <= bus.i_d;
      vld_q[0] <= bus.i_vld & ~cfg_acc_c;
    end
  end

  for (genvar k = 1; k < DMAX; k++) begin : g_stage
    // Shift stage k into k+1; data survives reconfiguration, valid does not.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        dat_q[k] <= '0;
        vld_q[k] <= 1'b0;
      end else begin
        dat_q[k] <= dat_q[k-1];
        vld_q[k] <= vld_q[k-1] & ~cfg_acc_c;
      end
    end
  end

  // Output tap select; a zero delay bypasses the line entirely.
  always_comb begin
    inv_mask_c = {WIDTH{inv_q}};
    sel_c      = dly_q - DLY_W'(1);
    if (dly_q == '0) begin
      z_c   = bus.i_d ^ inv_mask_c;
      vld_c = bus.i_vld;
    end else begin
      z_c   = dat_q[sel_c] ^ inv_mask_c;
      vld_c = vld_q[sel_c];
    end
  end

  assign bus.o_z       = z_c;
  assign bus.o_vld     = vld_c;
  assign bus.o_dly     = dly_q;
  assign bus.o_cfg_rdy = cfg_rdy_c;
  assign bus.o_busy    = busy_c;

endmodule

// File: tb/tb_delay_line_prog.sv
// Scoreboard bench for delay_line_prog: a history-based reference model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_delay_line_prog;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned DLY_W   = 4;
  localparam int unsigned RST_DLY = 10;
  localparam int          HIST    = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  delay_line_prog_if #(.WIDTH(WIDTH), .DLY_W(DLY_W)) bus ();

  delay_line_prog #(
    .WIDTH  (WIDTH),
    .DLY_W  (DLY_W),
    .RST_DLY(RST_DLY)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    int               cyc;
    logic             vld;
    logic [WIDTH-1:0] z;
    logic [DLY_W-1:0] dly;
    logic             busy;
  } stat_t;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] z;
  } dat_t;

  stat_t sq[$];
  dat_t  dq[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what entered at every cycle, plus the last cycle whose
  // edge invalidated everything older (config accept or reset).
  logic [WIDTH-1:0] hist_d [HIST];
  bit               hist_v [HIST];
  int cyc       = 0;
  int m_dly     = 0;
  bit m_inv     = 1'b0;
  int m_flush   = 0;
  int last_kill = -1;
  int last_rst  = -1;
  bit known     = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict its outputs, then advance the model past the edge.
  task automatic step(input bit r, input logic [WIDTH-1:0] d, input bit v,
                      input bit cv, input logic [DLY_W-1:0] cd, input bit ci);
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] ez;
    bit               ev;
    int               src;
    @(posedge clk);
    #1;
    rst           = r;
    bus.i_d       = d;
    bus.i_vld     = v;
    bus.i_cfg_vld = cv;
    bus.i_cfg_dly = cd;
    bus.i_cfg_inv = ci;
    hist_d[cyc] = d;
    hist_v[cyc] = v;
    if (known) begin
      mask = {WIDTH{m_inv}};
      if (m_dly == 0) begin
        ev = v;
        ez = d ^ mask;
      end else begin
        src = cyc - m_dly;
        if (src <= last_rst) begin
          ev = 1'b0;
          ez = mask;
        end else begin
          ev = hist_v[src] && (src > last_kill);
          ez = hist_d[src] ^ mask;
        end
      end
      sq.push_back('{cyc, ev, ez, DLY_W'(m_dly), (m_flush > 0)});
      if (ev) dq.push_back('{cyc, ez});
    end
    if (r) begin
      m_dly     = int'(RST_DLY);
      m_inv     = 1'b0;
      m_flush   = 0;
      last_kill = cyc;
      last_rst  = cyc;
      known     = 1'b1;
    end else if (known) begin
      if (m_flush > 0) begin
        m_flush--;
      end else if (cv) begin
        m_dly     = int'(cd);
        m_inv     = ci;
        m_flush   = (cd == '0) ? 1 : int'(cd);
        last_kill = cyc;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic rnd(input int n);
    for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), 1'($urandom), 1'b0, '0, 1'b0);
  endtask

  // Monitor: status compared every cycle, data popped whenever o_vld is presented.
  always @(negedge clk) begin
    stat_t s;
    dat_t  e;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("o_vld",     32'(bus.o_vld),     32'(s.vld),   s.cyc);
      chk("o_z",       32'(bus.o_z),       32'(s.z),     s.cyc);
      chk("o_dly",     32'(bus.o_dly),     32'(s.dly),   s.cyc);
      chk("o_busy",    32'(bus.o_busy),    32'(s.busy),  s.cyc);
      chk("o_cfg_rdy", 32'(bus.o_cfg_rdy), 32'(!s.busy), s.cyc);
      if (bus.o_vld === 1'b1) begin
        if (dq.size() == 0) begin
          chk("sb_unexpected_vld", 32'(1), 32'(0), s.cyc);
        end else begin
          e = dq.pop_front();
          chk("sb_cycle", 32'(s.cyc), 32'(e.cyc), s.cyc);
          chk("sb_data",  32'(bus.o_z), 32'(e.z), s.cyc);
        end
      end
    end
  end

  initial begin
    bus.i_d       = '0;
    bus.i_vld     = 1'b0;
    bus.i_cfg_vld = 1'b0;
    bus.i_cfg_dly = '0;
    bus.i_cfg_inv = 1'b0;

    // Reset, then idle with reset values on the outputs.
    step(1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(3);

    // Single pulse at the reset delay of 10.
    step(1'b0, WIDTH'(1), 1'b1, 1'b0, '0, 1'b0);
    idle(12);

    // Delay 3 with inversion, zero data entering right after acceptance.
    step(1'b0, WIDTH'($urandom), 1'b1, 1'b1, DLY_W'(3), 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(6);

    // Zero delay: combinational pass-through.
    step(1'b0, WIDTH'($urandom), 1'b0, 1'b1, '0, 1'b0);
    rnd(12);

    // Valids in flight at delay 15 cut off by a reconfig to 2.
    step(1'b0, WIDTH'($urandom), 1'b0, 1'b1, DLY_W'(15), 1'b0);
    idle(16);
    stream(8);
    step(1'b0, WIDTH'($urandom), 1'b1, 1'b1, DLY_W'(2), 1'b0);
    stream(10);
    idle(16);

    // Config held through flush: accepted once at the first RUN edge.
    step(1'b0, WIDTH'($urandom), 1'b1, 1'b1, DLY_W'(5), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, WIDTH'($urandom), 1'($urandom), 1'b1, DLY_W'(7), 1'b1);
    rnd(12);

    // Reset in the middle of a flush with valids in flight.
    step(1'b0, WIDTH'($urandom), 1'b1, 1'b1, DLY_W'(9), 1'b1);
    stream(4);
    step(1'b1, WIDTH'($urandom), 1'b1, 1'b0, '0, 1'b0);
    rnd(14);

    // Random traffic with occasional reconfig and reset.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 149) == 0), WIDTH'($urandom), 1'($urandom),
           1'($urandom_range(0, 24) == 0), DLY_W'($urandom), 1'($urandom));
    end
    idle(20);

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(dq.size()), 32'(0), cyc);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/delay_line_prog.md
DELAY_LINE_PROG -- requirements
Module: delay_line_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 1: data width per stage.
REQ-002 SHALL have parameter DLY_W, default 4: delay select width; DMAX = 2^DLY_W-1 stages.
REQ-003 SHALL have parameter RST_DLY, default 10: delay loaded at reset, range 0..DMAX.
REQ-004 SHALL have port i_clk  input  1  clock; single clock domain, all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_d  input  WIDTH  data into stage 0.
REQ-007 SHALL have port i_vld  input  1  i_d qualifier.
REQ-008 SHALL have port i_cfg_vld  input  1  config request.
REQ-009 SHALL have port i_cfg_dly  input  DLY_W  requested delay in cycles.
REQ-010 SHALL have port i_cfg_inv  input  1  requested output inversion.
REQ-011 SHALL have port o_cfg_rdy  output  1  config accept.
REQ-012 SHALL have port o_z  output  WIDTH  delayed, optionally inverted data.
REQ-013 SHALL have port o_vld  output  1  o_z qualifier.
REQ-014 SHALL have port o_dly  output  DLY_W  active delay.
REQ-015 SHALL have port o_busy  output  1  flush in progress.

Function
REQ-016 SHALL hold DMAX registered stages s[1..DMAX] of WIDTH data bits plus 1 valid bit each; per cycle, s[1] <= {i_vld,i_d} and s[k] <= s[k-1].
REQ-017 SHALL hold active delay D and inversion flag INV in registers; o_dly = D.
REQ-018 SHALL drive, for D>=1, o_z = s[D].data XOR {WIDTH{INV}} and o_vld = s[D].vld, giving exactly D cycles of latency.
REQ-019 SHALL drive, for D=0, o_z = i_d XOR {WIDTH{INV}} and o_vld = i_vld, combinationally with zero latency.
REQ-020 SHALL use a two-state FSM: RUN (o_cfg_rdy=1, o_busy=0) and FLUSH (o_cfg_rdy=0, o_busy=1).
REQ-021 SHALL accept config when i_cfg_vld & o_cfg_rdy at a rising edge; that edge sets D <= i_cfg_dly, INV <= i_cfg_inv, clears all stage valid bits, loads flush counter with i_cfg_dly, and enters FLUSH.
REQ-022 SHALL, on the acceptance edge, still shift s[1] <= {0,i_d}: data entering on that cycle is dropped (valid cleared).
REQ-023 SHALL, in FLUSH, decrement the counter each cycle and return to RUN on the edge where the counter equals 0; FLUSH therefore lasts max(D,1) cycles.
REQ-024 SHALL ignore i_cfg_vld while in FLUSH, with no effect on D, INV, or counter.
REQ-025 SHALL keep shifting i_d/i_vld during FLUSH; valid data entering during FLUSH propagates normally.
REQ-026 SHALL leave stage data bits uncleared on reconfig; only valid bits clear.
REQ-027 SHALL treat i_cfg_dly = D with i_cfg_inv = INV as a normal reconfig, including flush.

Reset
REQ-028 SHALL, when i_rst=1 at a rising edge, set all stage data and valid bits to 0, D <= RST_DLY, INV <= 0, counter <= 0, and state RUN.
REQ-029 SHALL give reset priority over config acceptance and shifting; a reset mid-FLUSH returns to RUN with D = RST_DLY.
REQ-030 SHALL drive, after reset with D>=1: o_z=0, o_vld=0, o_cfg_rdy=1, o_busy=0, o_dly=RST_DLY.

Verification
REQ-031 SHALL be checked with: reset, D=10, single i_vld pulse with i_d=1 at cycle 0 -> o_vld=1, o_z=1 at cycle 10 only.
REQ-032 SHALL be checked with: config dly=3, inv=1 accepted at cycle t -> o_busy=1 for cycles t+1..t+3, o_cfg_rdy=1 at t+4; i_d=0 with valid at t+1 -> o_z=1 (WIDTH=1), o_vld=1 at t+4.
REQ-033 SHALL be checked with: D=0 config -> FLUSH 1 cycle; afterwards o_z tracks i_d in the same cycle, o_vld=i_vld.
REQ-034 SHALL be checked with: stream of 8 valids in flight at D=15, reconfig to dly=2 -> no o_vld from old data; new data emerges 2 cycles after entry.
REQ-035 SHALL be checked with: i_cfg_vld held high during FLUSH with a different dly -> ignored until RUN, then accepted once on the first RUN edge.
REQ-036 SHALL be checked with: i_rst asserted mid-FLUSH with valids in flight -> next cycle o_vld=0, o_busy=0, o_dly=RST_DLY.
